// File: rtl/pal_skid_stage.sv
// Two-entry registered skid stage: tags each accepted beat and supports a synchronous flush.
// The first beat appears one cycle after accept. o_ready comes only from the state register, so there is no ready feed-through.
module pal_skid_stage #(
  parameter int W_DATA = 32,
  parameter int W_TAG  = 4
) (
  input  logic              i_clk,
  input  logic              resetn,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [W_DATA-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [W_DATA-1:0] o_data,
  output logic [W_TAG-1:0]  o_tag,
  output logic [1:0]        o_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [W_DATA-1:0] m_dat_q, m_dat_d;
  logic [W_DATA-1:0] s_dat_q, s_dat_d;
  logic [W_TAG-1:0]  m_tag_q, m_tag_d;
  logic [W_TAG-1:0]  s_tag_q, s_tag_d;
  logic [W_TAG-1:0]  tag_cnt_q, tag_cnt_d;
  logic              accept;
  logic              emit;

  assign o_ready = (state_q != FULL);
  assign o_valid = (state_q != EMPTY);
  assign accept  = i_valid & o_ready;
  assign emit    = o_valid & i_ready;
  assign o_data  = m_dat_q;
  assign o_tag   = m_tag_q;

  always_comb begin
    o_count = 2'd0;
    case (state_q)
      ONE:     o_count = 2'd1;
      FULL:    o_count = 2'd2;
      default: o_count = 2'd0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    m_dat_d   = m_dat_q;
    m_tag_d   = m_tag_q;
    s_dat_d   = s_dat_q;
    s_tag_d   = s_tag_q;
    tag_cnt_d = tag_cnt_q;
    // A flush discards any beat accepted in the same cycle, tag included.
    if (i_flush) begin
      state_d = EMPTY;
    end else begin
      if (accept) tag_cnt_d = tag_cnt_q + {{(W_TAG-1){1'b0}}, 1'b1};
      case (state_q)
        EMPTY: begin
          if (accept) begin
            m_dat_d = i_data;
            m_tag_d = tag_cnt_q;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept && !emit) begin
            s_dat_d = i_data;
            s_tag_d = tag_cnt_q;
            state_d = FULL;
          end else if (emit && !accept) begin
            state_d = EMPTY;
          end else if (accept && emit) begin
            m_dat_d = i_data;
            m_tag_d = tag_cnt_q;
          end
        end
        FULL: begin
          if (emit) begin
            m_dat_d = s_dat_q;
            m_tag_d = s_tag_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= EMPTY;
      m_dat_q   <= '0;
      m_tag_q   <= '0;
      s_dat_q   <= '0;
      s_tag_q   <= '0;
      tag_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      m_dat_q   <= m_dat_d;
      m_tag_q   <= m_tag_d;
      s_dat_q   <= s_dat_d;
      s_tag_q   <= s_tag_d;
      tag_cnt_q <= tag_cnt_d;
    end
  end

endmodule
